// File: rtl/apb_master_ctrl.sv
// APB4 master fed by FWFT write-address/write-data/read-address FIFOs. Results go to a read-data FIFO
// or to a write-done pulse. It runs one transfer at a time, and reads and writes alternate when both are waiting.
module apb_master_ctrl #(
  parameter int DW  = 32,
  parameter int TMO = 16
) (
  input  logic              m_clk,
  input  logic              m_rst,
  input  logic [DW+2:0]     wa_rdata,
  input  logic              wa_empty,
  output logic              wa_pop,
  input  logic [DW/8+DW-1:0] wd_rdata,
  input  logic              wd_empty,
  output logic              wd_pop,
  input  logic [DW+2:0]     ra_rdata,
  input  logic              ra_empty,
  output logic              ra_pop,
  output logic [DW:0]       rd_wdata,
  input  logic              rd_full,
  output logic              rd_push,
  output logic              wr_done,
  output logic              wr_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DW-1:0]     paddr,
  output logic [2:0]        pprot,
  output logic [DW-1:0]     pwdata,
  output logic [DW/8-1:0]   pstrb,
  input  logic [DW-1:0]     prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int CW    = (TMO > 2) ? $clog2(TMO) : 1;
  localparam int TLAST = (TMO > 0) ? TMO - 1 : 0;

  state_t        state, state_nxt;
  logic          prio;
  logic [CW-1:0] cnt;
  logic          wr_ok, rd_ok, gnt_wr, gnt_rd, tmo_hit, done;

  always_comb begin
    wr_ok     = (state == IDLE) && !wa_empty && !wd_empty;
    rd_ok     = (state == IDLE) && !ra_empty && !rd_full;
    gnt_wr    = wr_ok && (!rd_ok || !prio) && !m_rst;
    gnt_rd    = rd_ok && (!wr_ok || prio) && !m_rst;
    tmo_hit   = (TMO != 0) && (cnt == CW'(TLAST)) && !pready;
    // Reset gates completion so an aborted transfer never reports.
    done      = (state == ACCESS) && (pready || tmo_hit) && !m_rst;
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_wr || gnt_rd) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wa_pop   = gnt_wr;
    wd_pop   = gnt_wr;
    ra_pop   = gnt_rd;
    rd_push  = done && !pwrite;
    wr_done  = done && pwrite;
    wr_err   = wr_done && (pready ? pslverr : 1'b1);
    rd_wdata = '0;
    if (rd_push) rd_wdata = pready ? {pslverr, prdata} : {1'b1, {DW{1'b0}}};
    psel     = (state != IDLE);
    penable  = (state == ACCESS);
    busy     = (state != IDLE);
  end

  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      state  <= IDLE;
      prio   <= 1'b0;
      cnt    <= '0;
      pwrite <= 1'b0;
      paddr  <= '0;
      pprot  <= '0;
      pwdata <= '0;
      pstrb  <= '0;
    end else begin
      state <= state_nxt;
      if (state == SETUP)       cnt <= '0;
      else if (state == ACCESS) cnt <= cnt + 1'b1;
      if (gnt_wr) begin
        prio   <= 1'b1;
        pwrite <= 1'b1;
        {pprot, paddr}  <= wa_rdata;
        {pstrb, pwdata} <= wd_rdata;
      end else if (gnt_rd) begin
        prio   <= 1'b0;
        pwrite <= 1'b0;
        {pprot, paddr} <= ra_rdata;
        pstrb  <= '0;
        pwdata <= '0;
      end
    end
  end

endmodule
